// File: rtl/rf_wb_pkg.sv
//------------------------------------------------------------------------------
// Module : rf_wb_pkg
// Brief  : Shared widths and load-buffer entry type for the RF write arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rf_wb_pkg;

    localparam int C_XLEN = 32;
    localparam int C_AW   = 5;

    typedef struct packed {
        logic              live;
        logic [C_AW-1:0]   rd;
        logic [C_XLEN-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_fifo.sv
//------------------------------------------------------------------------------
// Module : wb_load_fifo
// Brief  : In-order load writeback buffer with per-rd kill and age-ordered view.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_load_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  wb_entry_t       i_push_entry,
    input  logic            i_pop,
    input  logic            i_kill,
    input  logic [C_AW-1:0] i_kill_rd,
    output wb_entry_t       o_head,
    output logic            o_empty,
    output logic            o_full,
    output wb_entry_t       o_view [DEPTH]
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] C_LAST      = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH_CNT = CW'(DEPTH);
    localparam logic [PW:0]   C_DEPTH_EXT = (PW+1)'(DEPTH);

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == C_DEPTH_CNT);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Kill first, then the push: an incoming load never matches the kill rd
    // because the top drops it in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && (r_mem[i].rd == i_kill_rd)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
            end
        end
    end

    // o_view[0] is the oldest occupied slot; unoccupied slots read as dead.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW:0]   w_sum;
            logic [PW-1:0] w_idx;
            w_sum = {1'b0, r_rd_ptr} + (PW+1)'(k);
            if (w_sum >= C_DEPTH_EXT) begin
                w_sum = w_sum - C_DEPTH_EXT;
            end
            w_idx          = w_sum[PW-1:0];
            o_view[k]      = r_mem[w_idx];
            o_view[k].live = r_mem[w_idx].live && (CW'(k) < r_count);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
//------------------------------------------------------------------------------
// Module : rf_write_arbiter
// Brief  : Merges ALU and load writebacks onto the single RF write port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_write_arbiter
    import rf_wb_pkg::*;
#(
    parameter int XLEN  = C_XLEN,
    parameter int AW    = C_AW,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   fwd_rs1,
    input  logic [AW-1:0]   fwd_rs2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic            busy
);

    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic            w_alu_wr;
    logic            w_ld_acc;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic            w_head_issue;
    wb_entry_t       w_head;
    wb_entry_t       w_push_entry;
    wb_entry_t       w_view [DEPTH];

    assign w_alu_wr     = alu_valid && (alu_rd != '0);
    assign w_ld_acc     = ld_valid && ld_ready;
    assign w_head_issue = !w_empty && w_head.live && !w_alu_wr;
    assign w_bypass     = w_empty && !w_alu_wr && w_ld_acc && (ld_rd != '0);
    // A same-rd ALU write in the same cycle is younger, so the load is dropped.
    assign w_push       = w_ld_acc && (ld_rd != '0) && !w_bypass
                          && !(w_alu_wr && (alu_rd == ld_rd));
    // Dead heads drain without needing the write port.
    assign w_pop        = !w_empty && (!w_head.live || !w_alu_wr);
    assign w_push_entry = '{live: 1'b1, rd: ld_rd, data: ld_data};

    assign ld_ready = !w_full;

    wb_load_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill       (w_alu_wr),
        .i_kill_rd    (alu_rd),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_view       (w_view)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_alu_wr) begin
            r_we    <= 1'b1;
            r_waddr <= alu_rd;
            r_wdata <= alu_data;
        end else if (w_head_issue) begin
            r_we    <= 1'b1;
            r_waddr <= w_head.rd;
            r_wdata <= w_head.data;
        end else if (w_bypass) begin
            r_we    <= 1'b1;
            r_waddr <= ld_rd;
            r_wdata <= ld_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign busy     = !w_empty || r_we;

    // Buffer entries are younger than the output register; the scan runs
    // oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        if (fwd_rs1 != '0) begin
            if (r_we && (r_waddr == fwd_rs1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = r_wdata;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (w_view[k].live && (w_view[k].rd == fwd_rs1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = w_view[k].data;
                end
            end
        end
        if (fwd_rs2 != '0) begin
            if (r_we && (r_waddr == fwd_rs2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = r_wdata;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (w_view[k].live && (w_view[k].rd == fwd_rs2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = w_view[k].data;
                end
            end
        end
    end

endmodule

`default_nettype wire
